// File: rtl/tawas_thread_sched_if.sv
// tawas_thread_sched_if: control/status bundle between the tawas core and its thread scheduler
//   master: drives enable pulses, RCN stalls and hold; observes mask, stage IDs and idle
//   slave : the scheduler side
interface tawas_thread_sched_if;
    logic [31:0] thread_en_set;
    logic [31:0] thread_en_clr;
    logic [31:0] rcn_stall;
    logic        sched_hold;
    logic [31:0] thread_mask;
    logic        thread_load_en;
    logic [4:0]  thread_load;
    logic        thread_decode_en;
    logic [4:0]  thread_decode;
    logic        thread_store_en;
    logic [4:0]  thread_store;
    logic        idle;

    modport master (
        output thread_en_set, thread_en_clr, rcn_stall, sched_hold,
        input  thread_mask, thread_load_en, thread_load, thread_decode_en,
               thread_decode, thread_store_en, thread_store, idle
    );

    modport slave (
        input  thread_en_set, thread_en_clr, rcn_stall, sched_hold,
        output thread_mask, thread_load_en, thread_load, thread_decode_en,
               thread_decode, thread_store_en, thread_store, idle
    );
endinterface

// File: rtl/tawas_thread_sched.sv
// tawas_thread_sched: round-robin scheduler for 32 hardware threads, one instruction in flight per thread
//   clk  : core clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of tawas_thread_sched_if (enable pulses, RCN stalls, hold in;
//          enable mask, load/decode/store stage IDs and idle out)
module tawas_thread_sched #(
    parameter logic [31:0] RESET_MASK = 32'h0000_0001,
    parameter logic [4:0]  PTR_RESET  = 5'd31
) (
    input  logic                  clk,
    input  logic                  rst,
    tawas_thread_sched_if.slave   bus
);
    logic [31:0] mask_q, mask_d;
    logic [4:0]  ptr_q, ptr_d;
    logic        load_en_q, load_en_d, decode_en_q, store_en_q;
    logic [4:0]  load_q, load_d, decode_q, store_q;
    logic [31:0] inflight, eligible;
    logic [4:0]  sel, idx;
    logic        found;

    always_comb begin
        inflight = '0;
        if (load_en_q)   inflight[load_q]   = 1'b1;
        if (decode_en_q) inflight[decode_q] = 1'b1;
        if (store_en_q)  inflight[store_q]  = 1'b1;
        eligible = mask_q & ~bus.rcn_stall & ~inflight;
        // Scan ptr+1 .. ptr+32; the 5-bit add wraps, so ptr itself is the last candidate.
        sel   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            idx = ptr_q + 5'(k);
            if (!found && eligible[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        load_en_d = found && !bus.sched_hold;
        load_d    = load_en_d ? sel : load_q;
        ptr_d     = load_en_d ? sel : ptr_q;
        mask_d    = (mask_q | bus.thread_en_set) & ~bus.thread_en_clr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q      <= RESET_MASK;
            ptr_q       <= PTR_RESET;
            load_en_q   <= 1'b0;
            load_q      <= '0;
            decode_en_q <= 1'b0;
            decode_q    <= '0;
            store_en_q  <= 1'b0;
            store_q     <= '0;
        end else begin
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            load_en_q   <= load_en_d;
            load_q      <= load_d;
            decode_en_q <= load_en_q;
            decode_q    <= load_q;
            store_en_q  <= decode_en_q;
            store_q     <= decode_q;
        end
    end

    assign bus.thread_mask      = mask_q;
    assign bus.thread_load_en   = load_en_q;
    assign bus.thread_load      = load_q;
    assign bus.thread_decode_en = decode_en_q;
    assign bus.thread_decode    = decode_q;
    assign bus.thread_store_en  = store_en_q;
    assign bus.thread_store     = store_q;
    assign bus.idle             = ~found;
endmodule

// File: tb/tb_tawas_thread_sched.sv
// tb_tawas_thread_sched: directed and randomized checks of tawas_thread_sched against an issue-history model
module tb_tawas_thread_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    tawas_thread_sched_if bus();

    tawas_thread_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: enable mask, last-issued thread, and the thread issued on each of the
    // last three edges (-1 = none), newest first.
    logic [31:0] m_mask;
    int          m_ptr;
    int          hist[$];

    task automatic model_reset();
        m_mask = 32'h1;
        m_ptr  = 31;
        hist   = '{-1, -1, -1};
    endtask

    function automatic logic [31:0] m_elig(input logic [31:0] st);
        logic [31:0] e;
        e = m_mask & ~st;
        foreach (hist[i]) if (hist[i] >= 0) e[hist[i]] = 1'b0;
        return e;
    endfunction

    function automatic int m_pick(input logic [31:0] e);
        for (int k = 1; k <= 32; k++) begin
            if (e[(m_ptr + k) % 32]) return (m_ptr + k) % 32;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("mask", bus.thread_mask, m_mask);
        chk("load_en", 32'(bus.thread_load_en), 32'(hist[0] >= 0));
        chk("decode_en", 32'(bus.thread_decode_en), 32'(hist[1] >= 0));
        chk("store_en", 32'(bus.thread_store_en), 32'(hist[2] >= 0));
        if (hist[0] >= 0) chk("load_id", 32'(bus.thread_load), hist[0]);
        if (hist[1] >= 0) chk("decode_id", 32'(bus.thread_decode), hist[1]);
        if (hist[2] >= 0) chk("store_id", 32'(bus.thread_store), hist[2]);
    endtask

    // One clock: starts and ends at a falling edge.
    task automatic cyc(input logic [31:0] s, input logic [31:0] c, input logic [31:0] st, input logic h);
        logic [31:0] e;
        int          pick;
        bus.thread_en_set = s;
        bus.thread_en_clr = c;
        bus.rcn_stall     = st;
        bus.sched_hold    = h;
        #1;
        e    = m_elig(st);
        pick = m_pick(e);
        chk("idle", 32'(bus.idle), 32'(e == 0));
        @(posedge clk);
        if (pick >= 0 && !h) m_ptr = pick;
        hist.push_front((pick >= 0 && !h) ? pick : -1);
        void'(hist.pop_back());
        m_mask = (m_mask | s) & ~c;
        #1;
        chk_outputs();
        @(negedge clk);
    endtask

    initial begin
        bus.thread_en_set = '0;
        bus.thread_en_clr = '0;
        bus.rcn_stall     = '0;
        bus.sched_hold    = 1'b0;
        model_reset();
        #12;
        chk_outputs();
        chk("reset_idle", 32'(bus.idle), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        // Only thread 0 enabled: issues every fourth cycle.
        repeat (12) cyc('0, '0, '0, 1'b0);
        // Four threads: one issue per cycle.
        cyc(32'hF, '0, '0, 1'b0);
        repeat (12) cyc('0, '0, '0, 1'b0);
        // Thread 2 stalled on RCN.
        repeat (8) cyc('0, '0, 32'h4, 1'b0);
        repeat (8) cyc('0, '0, '0, 1'b0);
        // Threads 30, 31, 0 across the wrap point.
        cyc('0, 32'hF, '0, 1'b0);
        cyc(32'hC000_0001, '0, '0, 1'b0);
        repeat (12) cyc('0, '0, '0, 1'b0);
        // Simultaneous set/clear of thread 1: clear wins.
        cyc(32'h2, 32'h2, '0, 1'b0);
        chk("set_clr_bit1", 32'(bus.thread_mask[1]), 32'd0);
        repeat (4) cyc('0, '0, '0, 1'b0);
        // Disable everything: pipeline drains.
        cyc('0, 32'hFFFF_FFFF, '0, 1'b0);
        repeat (4) cyc('0, '0, '0, 1'b0);
        chk("drained_idle", 32'(bus.idle), 32'd1);
        // Four threads with a five-cycle hold.
        cyc(32'hF, '0, '0, 1'b0);
        repeat (4) cyc('0, '0, '0, 1'b0);
        repeat (5) cyc('0, '0, '0, 1'b1);
        repeat (6) cyc('0, '0, '0, 1'b0);
        // Random traffic.
        repeat (300) begin
            cyc($urandom & $urandom & $urandom, $urandom & $urandom & $urandom & $urandom,
                $urandom & $urandom, $urandom_range(0, 7) == 0);
        end
        // Asynchronous reset mid-run, checked without a clock edge.
        cyc(32'hFF, '0, '0, 1'b0);
        repeat (3) cyc('0, '0, '0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        @(negedge clk);
        rst = 1'b1;
        repeat (6) cyc('0, '0, '0, 1'b0);
        repeat (100) begin
            cyc($urandom & $urandom, $urandom & $urandom & $urandom,
                $urandom & $urandom & $urandom, $urandom_range(0, 5) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tawas_thread_sched.md
Name: tawas_thread_sched

Overview:
- Hardware thread scheduler for the tawas multi-threaded core.
- Each cycle it picks one eligible thread of 32 using round-robin order.
- It issues the thread into the fetch/load stage and tracks its ID through the decode and store stages.
- It owns the thread enable mask and honours per-thread RCN load stalls, so that no thread has more than one instruction in flight.

Parameters:
- RESET_MASK, 32'h00000001: thread enable mask value after reset (thread 0 runs out of reset).
- PTR_RESET, 5'd31: last-issued pointer value at reset, so the first search starts at thread 0.

Ports:
- clk  in  1  core clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- thread_en_set  in  32  one-cycle pulses; each set bit enables the matching thread.
- thread_en_clr  in  32  one-cycle pulses; each set bit disables the matching thread.
- rcn_stall  in  32  level; a set bit means that thread waits on an outstanding RCN load.
- sched_hold  in  1  level; suppresses new issue while the pipeline keeps draining.
- thread_mask  out  32  current registered enable mask.
- thread_load_en  out  1  a valid thread is in the load stage this cycle.
- thread_load  out  5  thread ID in the load stage.
- thread_decode_en  out  1  a valid thread is in the decode stage.
- thread_decode  out  5  thread ID in the decode stage.
- thread_store_en  out  1  a valid thread is in the store stage.
- thread_store  out  5  thread ID in the store stage.
- idle  out  1  combinational; no thread is eligible this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - thread_mask=RESET_MASK, ptr=PTR_RESET.
  - All *_en=0 and all thread IDs=0.
  - Reset mid-operation kills every in-flight stage immediately.
- Mask update: mask <= (mask | thread_en_set) & ~thread_en_clr.
  - If the same bit is set and cleared in one cycle, clear wins.
  - Eligibility uses the registered mask, so a change takes effect one cycle after the pulse.
- Disabling an in-flight thread does not cancel its current stages; it completes normally.
- In-flight vector: inflight[i]=1 if thread i is valid in the load, decode or store stage.
- Eligibility: eligible[i] = mask[i] & ~rcn_stall[i] & ~inflight[i].
- Selection (combinational):
  - Pick the first eligible thread searching ptr+1, ptr+2, ... with mod-32 wrap; ptr itself is the last candidate.
  - idle = ~|eligible.
- Issue (registered):
  - If !idle and !sched_hold: thread_load_en<=1, thread_load<=sel, ptr<=sel.
  - Otherwise thread_load_en<=0; thread_load and ptr hold their values.
- Pipeline shift, every cycle unconditionally:
  - decode <= load (both en and ID).
  - store <= decode (both en and ID).
  - Latency is fixed: issue edge -> decode one cycle later -> store two cycles later.
- Rate limits:
  - A single eligible thread issues at most once every 4 cycles.
  - With 4 or more eligible threads, one issue occurs every cycle.
- rcn_stall is sampled combinationally. A stall asserted in the same cycle a thread would be chosen blocks that choice.
- Wrap-around: after ptr=31, the search starts at thread 0.
- All-disabled mask: idle=1 and no issue; the pipeline drains to all-invalid in 3 cycles.

Test Plan:
1. Release reset with defaults, no stimulus -> thread_load_en=1 with thread_load=0 on the first edge, then every 4 cycles; decode/store follow at +1/+2 cycles; thread_mask=32'h1.
2. Pulse thread_en_set=32'h0000000F -> issue order 0,1,2,3,0,1,... with one thread per cycle and no gaps; thread_mask=32'hF.
3. Threads 0-3 enabled, hold rcn_stall[2]=1 for 8 cycles -> order 0,1,3, then a bubble (0 still in flight), then 0,1,3,...; thread 2 issues within 1 cycle after the stall drops.
4. Enable threads 30, 31, 0, then start from ptr=29 -> issue 30,31,0,30,... proving mod-32 wrap.
5. thread_en_set and thread_en_clr both = 32'h2 in the same cycle -> mask bit 1 stays 0 and thread 1 never issues; thread_en_clr=32'hF mid-run -> at most 3 further store-stage cycles, then idle=1 with all *_en=0.
6. sched_hold=1 for 5 cycles with 4 threads active -> thread_load_en=0 for 5 cycles, decode/store drain, ptr unchanged; the next issue continues the round robin. Assert rst=0 mid-run -> all *_en=0 and mask=32'h1 immediately, without waiting for a clock.
